// File: rtl/seven_seg_pkg.sv
// Shared types, glyph table and hex decoder for the seven-segment scanner.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b0000000;

  // Segment order a..g, bit 6 = a; logical polarity (1 = lit).
  localparam seg_t HEX_GLYPHS [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    return HEX_GLYPHS[nibble];
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot prescaler and digit index for the scanner; flags the blank interval and frame end.
module seg_scan_timer #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  output logic [IDX_W-1:0] o_index,
  output logic             o_slot_blank,
  output logic             o_frame_done
);

  localparam int unsigned PRESC_W = $clog2(REFRESH_DIV);

  logic [PRESC_W-1:0] r_presc;
  logic [IDX_W-1:0]   r_index;
  logic               w_presc_last;
  logic               w_index_last;

  assign w_presc_last = (r_presc == PRESC_W'(REFRESH_DIV - 1));
  assign w_index_last = (r_index == IDX_W'(NUM_DIGITS - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_presc <= '0;
      r_index <= '0;
    end else if (w_presc_last) begin
      r_presc <= '0;
      r_index <= w_index_last ? '0 : r_index + IDX_W'(1);
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  assign o_index      = r_index;
  assign o_slot_blank = (32'(r_presc) < BLANK_CYCLES);
  // Gated by reset so an aborted frame never reports completion.
  assign o_frame_done = w_presc_last && w_index_last && !i_reset;

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit seven-segment driver with frame-synchronous double buffering,
// leading-zero blanking, decimal points, per-digit enable and an anti-ghosting blank interval.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned REFRESH_DIV    = 100000,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] AN_ONE = 1;
  localparam seg_t SEG_OFF_PIN = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic DP_OFF_PIN = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF_PIN = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [IDX_W-1:0] w_index;
  logic             w_slot_blank;
  logic             w_frame_done;

  seg_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES),
    .IDX_W       (IDX_W)
  ) u_timer (
    .i_clk       (clk),
    .i_reset     (reset),
    .o_index     (w_index),
    .o_slot_blank(w_slot_blank),
    .o_frame_done(w_frame_done)
  );

  logic [4*NUM_DIGITS-1:0] r_sh_value, r_act_value;
  logic [NUM_DIGITS-1:0]   r_sh_dp, r_act_dp;
  logic [NUM_DIGITS-1:0]   r_sh_en, r_act_en;
  logic                    r_pending;

  // Active copy uses the pre-edge shadow, so a load on the frame_done cycle waits a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh_value  <= '0;
      r_sh_dp     <= '0;
      r_sh_en     <= '0;
      r_act_value <= '0;
      r_act_dp    <= '0;
      r_act_en    <= '0;
      r_pending   <= 1'b0;
    end else begin
      if (w_frame_done && r_pending) begin
        r_act_value <= r_sh_value;
        r_act_dp    <= r_sh_dp;
        r_act_en    <= r_sh_en;
      end
      if (load) begin
        r_sh_value <= value;
        r_sh_dp    <= dp_in;
        r_sh_en    <= digit_en;
        r_pending  <= 1'b1;
      end else if (w_frame_done) begin
        r_pending <= 1'b0;
      end
    end
  end

  logic [3:0] w_nibble;
  logic       w_dp_bit;
  logic       w_en_bit;
  logic       w_lz_dark;
  logic       w_zero_run;

  // Walk from the most significant digit down, tracking whether everything so far is zero.
  always_comb begin
    w_nibble   = 4'h0;
    w_dp_bit   = 1'b0;
    w_en_bit   = 1'b0;
    w_lz_dark  = 1'b0;
    w_zero_run = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run && (r_act_value[4*i +: 4] == 4'h0);
      if (IDX_W'(i) == w_index) begin
        w_nibble  = r_act_value[4*i +: 4];
        w_dp_bit  = r_act_dp[i];
        w_en_bit  = r_act_en[i];
        w_lz_dark = blank_lz && (i != 0) && w_zero_run;
      end
    end
  end

  seg_t                  w_seg_log;
  logic                  w_dp_log;
  logic [NUM_DIGITS-1:0] w_an_log;

  always_comb begin
    w_seg_log = SEG_BLANK;
    w_dp_log  = 1'b0;
    w_an_log  = '0;
    if (!w_slot_blank && w_en_bit && !w_lz_dark) begin
      w_an_log  = AN_ONE << w_index;
      w_seg_log = hex_to_seg(w_nibble);
      w_dp_log  = w_dp_bit;
    end
  end

  seg_t                  r_seg;
  logic                  r_dp;
  logic [NUM_DIGITS-1:0] r_an;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg <= SEG_OFF_PIN;
      r_dp  <= DP_OFF_PIN;
      r_an  <= AN_OFF_PIN;
    end else begin
      r_seg <= w_seg_log ^ SEG_OFF_PIN;
      r_dp  <= w_dp_log ^ DP_OFF_PIN;
      r_an  <= w_an_log ^ AN_OFF_PIN;
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_done = w_frame_done;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench: stimulus queues expected lit-slot pins per frame; a monitor pops on every lit cycle.
module tb_seven_seg_scanner;

  localparam int unsigned ND = 4;
  localparam int unsigned RD = 4;
  localparam int unsigned BC = 1;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = '0;
  logic        blank_lz = 1'b0;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  seven_seg_scanner #(
    .NUM_DIGITS    (ND),
    .REFRESH_DIV   (RD),
    .BLANK_CYCLES  (BC),
    .SEG_ACTIVE_LOW(1),
    .AN_ACTIVE_LOW (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .value     (value),
    .dp_in     (dp_in),
    .digit_en  (digit_en),
    .blank_lz  (blank_lz),
    .load      (load),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } pin_t;

  pin_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  logic [15:0] m_sh_val, m_act_val;
  logic [3:0]  m_sh_dp, m_act_dp, m_sh_en, m_act_en;
  bit          m_pending;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pins sampled on the falling edge.
  initial begin
    int   gap;
    pin_t e;
    gap = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        gap = 0;
      end else if (mon_en) begin
        gap++;
        check("an_at_most_one", 32'($countones(~an) <= 1), 1);
        if (frame_done) begin
          check("frame_period", gap, 16);
          gap = 0;
        end
        if (an != 4'hF) begin
          if (exp_q.size() == 0) begin
            check("unexpected_lit_an", an, 4'hF);
          end else begin
            e = exp_q.pop_front();
            check("slot_an", an, e.an);
            check("slot_seg", seg, e.seg);
            check("slot_dp", dp, e.dp);
          end
        end
      end
    end
  end

  task automatic wait_fd();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (frame_done) got = 1'b1;
    end
    check("frame_done_seen", got, 1);
  endtask

  task automatic push_frame();
    pin_t e;
    bit   lz;
    for (int d = 0; d < 4; d++) begin
      lz = blank_lz && (d > 0) && ((m_act_val >> (4 * d)) == 16'h0);
      if (m_act_en[d] && !lz) begin
        e.an  = ~(4'b0001 << d);
        e.seg = ~GLYPH[m_act_val[4*d +: 4]];
        e.dp  = ~m_act_dp[d];
        for (int c = 0; c < int'(RD - BC); c++) exp_q.push_back(e);
      end
    end
  endtask

  // Returns on the falling edge of the frame_done cycle.
  task automatic next_frame();
    wait_fd();
    if (m_pending) begin
      m_act_val = m_sh_val;
      m_act_dp  = m_sh_dp;
      m_act_en  = m_sh_en;
      m_pending = 1'b0;
    end
    push_frame();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    value     = v;
    dp_in     = d;
    digit_en  = e;
    load      = 1'b1;
    m_sh_val  = v;
    m_sh_dp   = d;
    m_sh_en   = e;
    m_pending = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic model_reset();
    m_sh_val = '0; m_act_val = '0;
    m_sh_dp  = '0; m_act_dp  = '0;
    m_sh_en  = '0; m_act_en  = '0;
    m_pending = 1'b0;
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_an"}, an, 4'hF);
    check({tag, "_seg"}, seg, 7'h7F);
    check({tag, "_dp"}, dp, 1'b1);
    check({tag, "_frame_done"}, frame_done, 1'b0);
  endtask

  initial begin
    model_reset();
    mon_en = 1'b1;
    reset  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_pins("reset");
    reset = 1'b0;

    @(negedge clk);
    do_load(16'h1A2F, 4'b0100, 4'hF);
    next_frame();
    @(posedge clk);
    @(posedge clk);
    #1 check("slot_start_dark", an, 4'hF);
    @(posedge clk);
    #1 check("first_lit_digit0", an, 4'hE);

    // Mid-frame load must not disturb the frame in progress.
    next_frame();
    repeat (6) @(negedge clk);
    do_load(16'h0000, 4'b0000, 4'hF);
    blank_lz = 1'b1;

    // Load on the frame_done cycle: this frame takes the older shadow.
    next_frame();
    do_load(16'h0070, 4'b0000, 4'hF);
    next_frame();

    repeat (3) @(negedge clk);
    do_load(16'h8888, 4'b1001, 4'b1010);
    next_frame();
    next_frame();

    // Reset in digit 2's slot.
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    check_reset_pins("midframe_reset");
    reset = 1'b0;

    @(negedge clk);
    do_load(16'hD04C, 4'b1000, 4'hF);
    next_frame();
    next_frame();

    wait_fd();
    @(posedge clk);
    @(posedge clk);
    #1 mon_en = 1'b0;
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
